// File: rtl/dom_shared_mul_gfn_hs.sv
// Domain-oriented masked GF(2^N) multiplier with valid/ready handshake and back-pressure.
// Build option: define DOM_MUL_ZEROIZE_EN to clear stage registers whenever they empty.
module dom_shared_mul_gfn_hs #(
  parameter int unsigned N       = 2,
  parameter logic [N:0]  POLY    = 3'b111,
  parameter int unsigned SHARES  = 2,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                              ClkxCI,
  input  logic                              RstxBI,
  input  logic                              InValidxSI,
  output logic                              InReadyxSO,
  input  logic [N*SHARES-1:0]               _XxDI,
  input  logic [N*SHARES-1:0]               _YxDI,
  input  logic [N*SHARES*(SHARES-1)/2-1:0]  _ZxDI,
  output logic                              OutValidxSO,
  input  logic                              OutReadyxSI,
  output logic [N*SHARES-1:0]               _QxDO
);

  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      acc = (acc << 1) ^ (acc[N-1] ? POLY[N-1:0] : '0);
      if (b[N-1-i]) acc = acc ^ a;
    end
    return acc;
  endfunction

  function automatic int unsigned pair_idx(input int unsigned i, input int unsigned j);
    int unsigned lo;
    int unsigned hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Diagonal entries hold the inner term, off-diagonal the blinded cross terms,
  // so each output share is simply the XOR of its row.
  logic [N-1:0] s1_d [SHARES][SHARES];
  logic [N-1:0] s1_q [SHARES][SHARES];
  logic         v1;
  logic [N*SHARES-1:0] q_comb;

  always_comb begin
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        s1_d[i][j] = gf_mul(_XxDI[i*N +: N], _YxDI[j*N +: N]);
        if (i != j) s1_d[i][j] = s1_d[i][j] ^ _ZxDI[pair_idx(i, j)*N +: N];
      end
    end
  end

  always_comb begin
    q_comb = '0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        q_comb[i*N +: N] = q_comb[i*N +: N] ^ s1_q[i][j];
      end
    end
  end

  // InReadyxSO is exactly the stage-1 advance condition in both output modes.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      v1   <= 1'b0;
      s1_q <= '{default: '0};
    end else if (InReadyxSO) begin
      v1 <= InValidxSI;
      if (InValidxSI) begin
        s1_q <= s1_d;
      end
`ifdef DOM_MUL_ZEROIZE_EN
      else begin
        s1_q <= '{default: '0};
      end
`endif
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                v2;
      logic                s2_load;
      logic [N*SHARES-1:0] q2;

      assign s2_load     = v1 & (~v2 | OutReadyxSI);
      assign InReadyxSO  = ~v1 | s2_load;
      assign OutValidxSO = v2;
      assign _QxDO       = q2;

      always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
          v2 <= 1'b0;
          q2 <= '0;
        end else if (s2_load) begin
          v2 <= 1'b1;
          q2 <= q_comb;
        end else if (v2 && OutReadyxSI) begin
          v2 <= 1'b0;
`ifdef DOM_MUL_ZEROIZE_EN
          q2 <= '0;
`endif
        end
      end
    end else begin : g_comb_out
      assign InReadyxSO  = ~v1 | OutReadyxSI;
      assign OutValidxSO = v1;
      assign _QxDO       = q_comb;
    end
  endgenerate

endmodule
